// File: rtl/el2_dccm_sram_sink.sv
// el2_dccm_sram_sink
// SRAM-side responder for the DCCM bank interface. Each bank is a separate
// single-port array with a one-cycle registered read. After reset (or on
// init_start) every bank is swept to all-zero words, which are valid SECDED
// codewords, before core accesses are honoured. A one-shot injector XORs a
// captured mask into the next read of a chosen bank so ECC checking can be
// exercised without touching the stored contents.
module el2_dccm_sram_sink #(
    parameter int DCCM_NUM_BANKS  = 4,
    parameter int DCCM_DEPTH      = 1024,
    parameter int DCCM_INDEX_BITS = $clog2(DCCM_DEPTH),
    parameter int DCCM_DATA_WIDTH = 32,
    parameter int DCCM_ECC_WIDTH  = 7,
    parameter int BANK_BITS       = (DCCM_NUM_BANKS > 1) ? $clog2(DCCM_NUM_BANKS) : 1
) (
    input  logic                                             clk,
    input  logic                                             rst_l,
    input  logic [DCCM_NUM_BANKS-1:0]                        dccm_clken,
    input  logic [DCCM_NUM_BANKS-1:0]                        dccm_wren_bank,
    input  logic [DCCM_NUM_BANKS-1:0][DCCM_INDEX_BITS-1:0]   dccm_addr_bank,
    input  logic [DCCM_NUM_BANKS-1:0][DCCM_DATA_WIDTH-1:0]   dccm_wr_data_bank,
    input  logic [DCCM_NUM_BANKS-1:0][DCCM_ECC_WIDTH-1:0]    dccm_wr_ecc_bank,
    output logic [DCCM_NUM_BANKS-1:0][DCCM_DATA_WIDTH-1:0]   dccm_bank_dout,
    output logic [DCCM_NUM_BANKS-1:0][DCCM_ECC_WIDTH-1:0]    dccm_bank_ecc,
    input  logic                                             init_start,
    output logic                                             init_done,
    input  logic                                             err_inj_arm,
    input  logic [BANK_BITS-1:0]                             err_inj_bank,
    input  logic [DCCM_DATA_WIDTH+DCCM_ECC_WIDTH-1:0]        err_inj_mask,
    output logic                                             err_inj_pending,
    output logic                                             err_inj_done
);

    localparam int WORD_W = DCCM_DATA_WIDTH + DCCM_ECC_WIDTH;
    localparam logic [DCCM_INDEX_BITS-1:0] LAST_IDX = DCCM_INDEX_BITS'(DCCM_DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                       state_p0;
    logic [DCCM_INDEX_BITS-1:0]   idx_p0;
    logic [BANK_BITS-1:0]         inj_bank_p0;
    logic [WORD_W-1:0]            inj_mask_p0;
    logic                         inj_hit;
    logic                         run;
    logic                         sweep_wr;

    // Word layout is {ecc, data}, matching the injector mask layout.
    logic [WORD_W-1:0]                     mem [DCCM_NUM_BANKS][DCCM_DEPTH];
    logic [DCCM_NUM_BANKS-1:0][WORD_W-1:0] rd_word_p1;

    assign run      = (state_p0 == ST_RUN);
    // Sweep writes are held off while reset is asserted so reset alone never
    // alters array contents.
    assign sweep_wr = (state_p0 == ST_INIT) && rst_l;

    // A read qualifies for corruption only if the arm is already registered
    // and no new arm arrives in the same cycle (a fresh arm takes priority).
    assign inj_hit = run && err_inj_pending && !err_inj_arm &&
                     dccm_clken[inj_bank_p0] && !dccm_wren_bank[inj_bank_p0];

    // Init/run sequencer: sweeps idx across every word, then honours the core.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_p0  <= ST_INIT;
            idx_p0    <= '0;
            init_done <= 1'b0;
        end else begin
            case (state_p0)
                ST_INIT: begin
                    idx_p0 <= idx_p0 + 1'b1;
                    if (idx_p0 == LAST_IDX) begin
                        state_p0  <= ST_RUN;
                        idx_p0    <= '0;
                        init_done <= 1'b1;
                    end
                end
                default: begin
                    if (init_start) begin
                        state_p0  <= ST_INIT;
                        idx_p0    <= '0;
                        init_done <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Array write port: zero sweep during init, core writes during run.
    always_ff @(posedge clk) begin
        for (int b = 0; b < DCCM_NUM_BANKS; b++) begin
            if (sweep_wr) begin
                mem[b][idx_p0] <= '0;
            end else if (run && dccm_clken[b] && dccm_wren_bank[b]) begin
                mem[b][dccm_addr_bank[b]] <= {dccm_wr_ecc_bank[b], dccm_wr_data_bank[b]};
            end
        end
    end

    // Registered read port per bank; the injected mask only affects the output copy.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rd_word_p1 <= '0;
        end else if (run) begin
            for (int b = 0; b < DCCM_NUM_BANKS; b++) begin
                if (dccm_clken[b] && !dccm_wren_bank[b]) begin
                    if (inj_hit && (inj_bank_p0 == BANK_BITS'(b))) begin
                        rd_word_p1[b] <= mem[b][dccm_addr_bank[b]] ^ inj_mask_p0;
                    end else begin
                        rd_word_p1[b] <= mem[b][dccm_addr_bank[b]];
                    end
                end
            end
        end
    end

    // One-shot injector: arm captures target, the qualifying read consumes it.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            inj_bank_p0     <= '0;
            inj_mask_p0     <= '0;
            err_inj_pending <= 1'b0;
            err_inj_done    <= 1'b0;
        end else begin
            err_inj_done <= inj_hit;
            if (err_inj_arm) begin
                inj_bank_p0     <= err_inj_bank;
                inj_mask_p0     <= err_inj_mask;
                err_inj_pending <= 1'b1;
            end else if (inj_hit) begin
                err_inj_pending <= 1'b0;
            end
        end
    end

    genvar gb;
    generate
        for (gb = 0; gb < DCCM_NUM_BANKS; gb++) begin : g_out
            assign dccm_bank_dout[gb] = rd_word_p1[gb][DCCM_DATA_WIDTH-1:0];
            assign dccm_bank_ecc[gb]  = rd_word_p1[gb][WORD_W-1:DCCM_DATA_WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_el2_dccm_sram_sink.sv
// Directed bench for el2_dccm_sram_sink built with a 16-word depth.
module tb_el2_dccm_sram_sink;

    localparam int NB = 4;
    localparam int DEPTH = 16;
    localparam int IB = 4;
    localparam int DW = 32;
    localparam int EW = 7;

    logic                    clk = 1'b0;
    logic                    rst_l;
    logic [NB-1:0]           clken;
    logic [NB-1:0]           wren;
    logic [NB-1:0][IB-1:0]   addr;
    logic [NB-1:0][DW-1:0]   wdata;
    logic [NB-1:0][EW-1:0]   wecc;
    logic [NB-1:0][DW-1:0]   dout;
    logic [NB-1:0][EW-1:0]   ecc;
    logic                    init_start;
    logic                    init_done;
    logic                    arm;
    logic [1:0]              inj_bank;
    logic [DW+EW-1:0]        inj_mask;
    logic                    pending;
    logic                    inj_done;

    int checks = 0;
    int failures = 0;

    el2_dccm_sram_sink #(
        .DCCM_NUM_BANKS (NB),
        .DCCM_DEPTH     (DEPTH),
        .DCCM_INDEX_BITS(IB),
        .DCCM_DATA_WIDTH(DW),
        .DCCM_ECC_WIDTH (EW)
    ) dut (
        .clk              (clk),
        .rst_l            (rst_l),
        .dccm_clken       (clken),
        .dccm_wren_bank   (wren),
        .dccm_addr_bank   (addr),
        .dccm_wr_data_bank(wdata),
        .dccm_wr_ecc_bank (wecc),
        .dccm_bank_dout   (dout),
        .dccm_bank_ecc    (ecc),
        .init_start       (init_start),
        .init_done        (init_done),
        .err_inj_arm      (arm),
        .err_inj_bank     (inj_bank),
        .err_inj_mask     (inj_mask),
        .err_inj_pending  (pending),
        .err_inj_done     (inj_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string                  name;
        logic [NB-1:0]          ck;
        logic [NB-1:0]          wr;
        logic [NB-1:0][IB-1:0]  ad;
        logic [NB-1:0][DW-1:0]  wd;
        logic [NB-1:0][EW-1:0]  we;
        logic [NB-1:0][DW-1:0]  ed;
        logic [NB-1:0][EW-1:0]  ee;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(input string n, input logic [3:0] ck, input logic [3:0] wr,
                                input logic [15:0] ad, input logic [127:0] wd, input logic [27:0] we,
                                input logic [127:0] ed, input logic [27:0] ee);
        vec_t v;
        v.name = n; v.ck = ck; v.wr = wr; v.ad = ad; v.wd = wd; v.we = we; v.ed = ed; v.ee = ee;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clken = '0; wren = '0; addr = '0; wdata = '0; wecc = '0;
        init_start = 1'b0; arm = 1'b0;
    endtask

    task automatic read_all(input logic [IB-1:0] a);
        idle();
        clken = 4'hF;
        addr = {a, a, a, a};
        step();
    endtask

    // Counts release-to-done: done must be low after 15 edges and high after 16.
    task automatic expect_done_after_16(input string tag);
        idle();
        repeat (15) step();
        check({tag, "_done_early"}, 64'(init_done), 64'd0);
        step();
        check({tag, "_done_rise"}, 64'(init_done), 64'd1);
    endtask

    initial begin
        idle();
        inj_bank = '0;
        inj_mask = '0;
        rst_l = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_ecc", 64'(ecc), 64'd0);
        check("rst_done", 64'(init_done), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_injdone", 64'(inj_done), 64'd0);
        rst_l = 1'b1;
        expect_done_after_16("boot");

        for (int i = 0; i < DEPTH; i++) begin
            read_all(IB'(i));
            check($sformatf("init_dout_idx%0d", i), 64'(dout), 64'd0);
            check($sformatf("init_ecc_idx%0d", i), 64'(ecc), 64'd0);
        end

        vecs[0] = mk("wr_b2", 4'b0100, 4'b0100, {4'h0, 4'h5, 4'h0, 4'h0},
                     {32'h0, 32'hDEADBEEF, 32'h0, 32'h0}, {7'h0, 7'h2A, 7'h0, 7'h0},
                     128'h0, 28'h0);
        vecs[1] = mk("rd_b2", 4'b0100, 4'b0000, {4'h0, 4'h5, 4'h0, 4'h0}, 128'h0, 28'h0,
                     {32'h0, 32'hDEADBEEF, 32'h0, 32'h0}, {7'h0, 7'h2A, 7'h0, 7'h0});
        vecs[2] = mk("wr_all", 4'b1111, 4'b1111, {4'h3, 4'h3, 4'h3, 4'h3},
                     {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                     {7'h04, 7'h03, 7'h02, 7'h01},
                     {32'h0, 32'hDEADBEEF, 32'h0, 32'h0}, {7'h0, 7'h2A, 7'h0, 7'h0});
        vecs[3] = mk("rd_all", 4'b1111, 4'b0000, {4'h3, 4'h3, 4'h3, 4'h3}, 128'h0, 28'h0,
                     {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                     {7'h04, 7'h03, 7'h02, 7'h01});
        vecs[4] = mk("rd_b0_idle", 4'b0001, 4'b0000, {4'h0, 4'h0, 4'h0, 4'h5}, 128'h0, 28'h0,
                     {32'h44444444, 32'h33333333, 32'h22222222, 32'h0},
                     {7'h04, 7'h03, 7'h02, 7'h00});
        vecs[5] = mk("wr_b1", 4'b0010, 4'b0010, {4'h0, 4'h0, 4'h5, 4'h0},
                     {32'h0, 32'h0, 32'h10, 32'h0}, 28'h0,
                     {32'h44444444, 32'h33333333, 32'h22222222, 32'h0},
                     {7'h04, 7'h03, 7'h02, 7'h00});
        vecs[6] = mk("rd_b2_b3", 4'b1100, 4'b0000, {4'h3, 4'h5, 4'h0, 4'h0}, 128'h0, 28'h0,
                     {32'h44444444, 32'hDEADBEEF, 32'h22222222, 32'h0},
                     {7'h04, 7'h2A, 7'h02, 7'h00});
        vecs[7] = mk("rd_b1", 4'b0010, 4'b0000, {4'h0, 4'h0, 4'h5, 4'h0}, 128'h0, 28'h0,
                     {32'h44444444, 32'hDEADBEEF, 32'h10, 32'h0},
                     {7'h04, 7'h2A, 7'h00, 7'h00});

        for (int v = 0; v < 8; v++) begin
            idle();
            clken = vecs[v].ck; wren = vecs[v].wr; addr = vecs[v].ad;
            wdata = vecs[v].wd; wecc = vecs[v].we;
            step();
            for (int b = 0; b < NB; b++) begin
                check($sformatf("%s_dout%0d", vecs[v].name, b), 64'(dout[b]), 64'(vecs[v].ed[b]));
                check($sformatf("%s_ecc%0d", vecs[v].name, b), 64'(ecc[b]), 64'(vecs[v].ee[b]));
            end
        end

        // Simple one-shot injection on bank 1.
        idle(); arm = 1'b1; inj_bank = 2'd1; inj_mask = 39'h1;
        step();
        check("arm1_pending", 64'(pending), 64'd1);
        check("arm1_done", 64'(inj_done), 64'd0);
        idle(); clken = 4'b0010; addr = {4'h0, 4'h0, 4'h5, 4'h0};
        step();
        check("inj1_dout", 64'(dout[1]), 64'h11);
        check("inj1_done", 64'(inj_done), 64'd1);
        check("inj1_pending", 64'(pending), 64'd0);
        step();
        check("inj1_reread", 64'(dout[1]), 64'h10);
        check("inj1_done_clr", 64'(inj_done), 64'd0);

        // Arm coincident with a read of the target bank: that read stays clean.
        idle(); arm = 1'b1; inj_bank = 2'd0; inj_mask = 39'h01_0000_0003;
        clken = 4'b0001; addr = {4'h0, 4'h0, 4'h0, 4'h3};
        step();
        check("coinc_dout", 64'(dout[0]), 64'h11111111);
        check("coinc_ecc", 64'(ecc[0]), 64'h01);
        check("coinc_pending", 64'(pending), 64'd1);
        check("coinc_done", 64'(inj_done), 64'd0);
        arm = 1'b0;
        step();
        check("coinc2_dout", 64'(dout[0]), 64'h11111112);
        check("coinc2_ecc", 64'(ecc[0]), 64'h00);
        check("coinc2_done", 64'(inj_done), 64'd1);
        check("coinc2_pending", 64'(pending), 64'd0);

        // Re-arm while pending retargets the injection.
        idle(); arm = 1'b1; inj_bank = 2'd3; inj_mask = 39'h0A;
        step();
        inj_bank = 2'd2; inj_mask = 39'hFF;
        step();
        check("rearm_pending", 64'(pending), 64'd1);
        idle(); clken = 4'b1000; addr = {4'h3, 4'h0, 4'h0, 4'h0};
        step();
        check("rearm_old_clean", 64'(dout[3]), 64'h44444444);
        check("rearm_old_nodone", 64'(inj_done), 64'd0);
        check("rearm_still_pending", 64'(pending), 64'd1);
        idle(); clken = 4'b0100; addr = {4'h0, 4'h5, 4'h0, 4'h0};
        step();
        check("rearm_new_dout", 64'(dout[2]), 64'hDEADBE10);
        check("rearm_new_done", 64'(inj_done), 64'd1);

        // Re-init: core traffic and a second init_start during the sweep are ignored.
        idle(); init_start = 1'b1;
        step();
        check("reinit_done_low", 64'(init_done), 64'd0);
        idle();
        clken = 4'hF; wren = 4'b0011; addr = '0;
        wdata = {32'h0, 32'h0, 32'hBBBB0000, 32'hAAAA0000}; wecc = {7'h0, 7'h0, 7'h11, 7'h22};
        for (int c = 0; c < 15; c++) begin
            init_start = (c == 8);
            step();
        end
        init_start = 1'b0;
        check("sweep_done_early", 64'(init_done), 64'd0);
        check("sweep_hold_dout2", 64'(dout[2]), 64'hDEADBE10);
        check("sweep_hold_dout3", 64'(dout[3]), 64'h44444444);
        step();
        check("sweep_done_rise", 64'(init_done), 64'd1);
        read_all(4'h0);
        check("post_sweep_a0", 64'(dout), 64'd0);
        check("post_sweep_a0_ecc", 64'(ecc), 64'd0);
        read_all(4'h3);
        check("post_sweep_a3", 64'(dout), 64'd0);
        read_all(4'h5);
        check("post_sweep_a5", 64'(dout), 64'd0);

        // Reset in the middle of a sweep.
        idle(); clken = 4'b1000; wren = 4'b1000; addr = {4'h1, 4'h0, 4'h0, 4'h0};
        wdata = {32'h77, 96'h0}; wecc = {7'h05, 21'h0};
        step();
        idle(); clken = 4'b1000; addr = {4'h1, 4'h0, 4'h0, 4'h0};
        step();
        check("pre_rst_dout3", 64'(dout[3]), 64'h77);
        idle(); init_start = 1'b1;
        step();
        idle();
        repeat (7) step();
        rst_l = 1'b0;
        #2;
        check("midrst_dout3", 64'(dout[3]), 64'd0);
        check("midrst_ecc3", 64'(ecc[3]), 64'd0);
        check("midrst_done", 64'(init_done), 64'd0);
        check("midrst_pending", 64'(pending), 64'd0);
        rst_l = 1'b1;
        expect_done_after_16("midrst");
        read_all(4'h1);
        check("midrst_read_a1", 64'(dout), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/el2_dccm_sram_sink.md
# el2_dccm_sram_sink

SRAM-side responder for the DCCM bank interface of the memory export bundle. It receives per-bank clock enables, write enables, addresses, data and ECC from the core's DCCM controller, and returns registered read data and ECC one cycle later. It also contains a post-reset zero-initialisation sequencer and a one-shot read-error injector for ECC verification. It sits outside the core, in the SoC/testbench memory wrapper, on the sink end of the `veer_sram_src` DCCM signals.

## Interface
- `DCCM_NUM_BANKS`, default 4: number of independent banks.
- `DCCM_DEPTH`, default 1024: words per bank, power of two.
- `DCCM_INDEX_BITS`, default $clog2(DCCM_DEPTH): per-bank address width.
- `DCCM_DATA_WIDTH`, default 32: data bits per word.
- `DCCM_ECC_WIDTH`, default 7: ECC bits per word.

Ports:
- `clk`  in  1  core clock. The block has one clock; reset is asynchronous and active-low.
- `rst_l`  in  1  asynchronous active-low reset.
- `dccm_clken`  in  [NUM_BANKS]  bank access enable.
- `dccm_wren_bank`  in  [NUM_BANKS]  bank write (1) / read (0).
- `dccm_addr_bank`  in  [NUM_BANKS][INDEX_BITS]  word index.
- `dccm_wr_data_bank`  in  [NUM_BANKS][DATA_WIDTH]  write data.
- `dccm_wr_ecc_bank`  in  [NUM_BANKS][ECC_WIDTH]  write ECC.
- `dccm_bank_dout`  out  [NUM_BANKS][DATA_WIDTH]  read data.
- `dccm_bank_ecc`  out  [NUM_BANKS][ECC_WIDTH]  read ECC.
- `init_start`  in  1  pulse; restarts zero-init.
- `init_done`  out  1  array initialised, core accesses honoured.
- `err_inj_arm`  in  1  pulse; arms one-shot injection.
- `err_inj_bank`  in  $clog2(NUM_BANKS)  target bank, sampled with arm.
- `err_inj_mask`  in  DATA_WIDTH+ECC_WIDTH  XOR mask {ecc,data}, sampled with arm.
- `err_inj_pending`  out  1  injection armed, not yet applied.
- `err_inj_done`  out  1  one-cycle pulse when the corrupted word is presented.

## Operation
- FSM states:
  - INIT: entered on reset. Index counter `idx` starts at 0. Each cycle, every bank writes data=0, ecc=0 at `idx` (all-zero is a valid SECDED codeword); `idx` increments. After the write of `idx`=DEPTH-1 → RUN.
  - RUN: `init_done`=1. Core accesses are honoured. `init_start`=1 → INIT with `idx`=0 and `init_done`=0 in the following cycle.
- INIT: core `dccm_clken` is ignored entirely (no write, no read); `dccm_bank_dout`/`dccm_bank_ecc` hold their values.
- RUN, per bank b, independently:
  - `clken[b]&wren[b]`: {ecc,data} written at `addr[b]`; outputs of bank b unchanged.
  - `clken[b]&~wren[b]`: array word at `addr[b]` registered to outputs.
  - `~clken[b]`: no access; outputs hold.
- Read-during-write is not possible within one bank (one port). A read never sees a write issued in the same cycle to another bank; the banks are separate arrays.
- Injector:
  - `err_inj_arm` captures bank/mask and sets `err_inj_pending`; this applies in any state.
  - The first RUN read of the captured bank issued in a cycle after the arm cycle has its returned {ecc,data} XORed with the mask. That cycle clears `pending` and pulses `err_inj_done` in the same cycle the corrupted word is visible.
  - The stored array content is never modified.
  - Arm while pending reloads bank/mask, and pending stays 1.
  - Arm coincident with the qualifying read: the new arm wins, pending stays 1, and that read is uncorrupted.
  - Mask 0 is legal: done pulses and data is unchanged.
- Array contents are not reset by `rst_l`; only the INIT sweep defines them.

## Timing
- Reset values: `dccm_bank_dout`=0, `dccm_bank_ecc`=0, `init_done`=0, `err_inj_pending`=0, `err_inj_done`=0; FSM=INIT, `idx`=0.
- With `rst_l` released before edge 0, init writes `idx` k on edge k. `init_done` is 1 after edge DEPTH-1, so the first honoured access is in cycle DEPTH.
- Read latency: 1 cycle. Address in cycle N → data visible after edge N, held until the next read on that bank.
- Back-to-back reads on a bank: one result per cycle.
- Write → read of the same address in the next cycle returns the new data.
- Reset asserted mid-INIT or mid-RUN: outputs return to reset values asynchronously, and the sweep restarts from 0.
- `init_start` asserted during INIT: ignored.

## Test plan
- Reset, DEPTH=16 build: `init_done` rises in cycle 16. Read every index of all banks → dout=0, ecc=0.
- RUN: write bank 2 addr 5 data 32'hDEADBEEF ecc 7'h2A, read it the next cycle → dout[2]=DEADBEEF and ecc[2]=2A one cycle later. Other banks' outputs are unchanged.
- Simultaneous writes to banks 0..3 with distinct data, then simultaneous reads → each bank returns its own data. An idle bank's output holds its prior value.
- Arm bank 1 with mask 39'h1 (data bit 0), then read bank 1 addr 5 holding 32'h10 → dout=32'h11 with `err_inj_done` pulse. A second read returns 32'h10 and `pending`=0.
- Arm bank 0 in the same cycle as a bank 0 read → that read is clean and `pending` stays 1. The next bank 0 read is corrupted.
- Write non-zero data, pulse `init_start`: core writes during the 16-cycle sweep are dropped and `init_done`=0. Afterward, all reads return 0. Assert `rst_l` at sweep index 7 → restart, and `init_done` is 1 16 cycles after release.
